search_ctrl: RTL and testbench
==============================

SEARCH_CTRL -- requirements
Module: search_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, symbol buffer entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_LEN, default 16, width of sym_count.
REQ-003 SHALL have port CLK  input  1  single clock, rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port BC_mode  input  1  session enable; high = search session active.
REQ-006 SHALL have port sym_in  input  2  symbol, A=00 C=01 G=10 T=11.
REQ-007 SHALL have port sym_valid  input  1  sym_in valid.
REQ-008 SHALL have port sym_ready  output  1  controller accepts sym_in.
REQ-009 SHALL have port dp_symbol  output  2  symbol presented to search datapath.
REQ-010 SHALL have port dp_fetch  output  1  one-cycle pulse, datapath table read at dp_symbol.
REQ-011 SHALL have port dp_update  output  1  one-cycle pulse, datapath commits interval.
REQ-012 SHALL have port dp_empty  input  1  datapath interval empty, sampled only in UPDATE cycle.
REQ-013 SHALL have port sym_count  output  CNT_LEN  symbols committed this session.
REQ-014 SHALL have port done  output  1  session finished (level).
REQ-015 SHALL have port matched  output  1  finished session ended with non-empty interval.

Function
REQ-016 FSM states SHALL be IDLE, RUN, FETCH, UPDATE, FLUSH, DONE.
REQ-017 IDLE: BC_mode=1 -> RUN next cycle; sym_count, matched cleared on that transition.
REQ-018 Input transfer SHALL occur when sym_valid && sym_ready; sym_ready = BC_mode && FIFO not full && state in {RUN,FETCH,UPDATE}.
REQ-019 RUN with FIFO non-empty -> FETCH; FETCH drives dp_symbol=FIFO head, dp_fetch=1.
REQ-020 UPDATE (always the cycle after FETCH) drives dp_update=1, holds dp_symbol, pops head, increments sym_count (saturating at all-ones).
REQ-021 Throughput SHALL be one symbol per 2 cycles; UPDATE -> FETCH directly when FIFO non-empty after pop and dp_empty=0.
REQ-022 UPDATE with dp_empty=1 -> FLUSH; FLUSH empties FIFO in one cycle -> DONE with matched=0.
REQ-023 BC_mode falling SHALL not abort an in-flight FETCH/UPDATE; buffered symbols SHALL still be processed.
REQ-024 RUN with BC_mode=0 and FIFO empty -> DONE with matched=1.
REQ-025 DONE: done=1, sym_count and matched held; BC_mode=1 -> RUN with sym_count, matched, done cleared.
REQ-026 dp_symbol SHALL be 00 and dp_fetch/dp_update 0 outside FETCH/UPDATE.
REQ-027 Push and pop in same UPDATE cycle SHALL both take effect; occupancy unchanged.

Reset
REQ-028 RST=1 SHALL asynchronously force state IDLE, FIFO empty, all outputs 0.
REQ-029 RST mid-session SHALL discard buffered symbols and in-flight step; no dp_update issued after release until a new FETCH.

Structure
REQ-030 Shared package mfa_pkg SHALL hold state enum, SYM_W=2, symbol encodings.
REQ-031 Symbol buffer SHALL be sub-module sym_fifo (FIFO_DEPTH x SYM_W, full/empty flags, push/pop/clear).

Verification
REQ-032 BC_mode=1, push 01,10,11 one per 2 cycles, dp_empty=0, BC_mode=0 -> dp_symbol 01,10,11 on fetch pulses, sym_count=3, done=1, matched=1.
REQ-033 push 8 symbols back-to-back, FIFO_DEPTH=4 -> sym_ready low at occupancy 4, no symbol lost or reordered, sym_count=8.
REQ-034 dp_empty=1 on 2nd UPDATE with 3 buffered -> FLUSH, done=1, matched=0, sym_count=2, no further dp_fetch.
REQ-035 RST pulse between FETCH and UPDATE -> all outputs 0 immediately, no dp_update, next session sym_count starts 0.
REQ-036 CNT_LEN=2, 5 symbols -> sym_count saturates at 3; DONE then BC_mode=1 -> sym_count=0, done=0.

Source files
------------

// File: rtl/mfa_pkg.sv
// mfa_pkg: shared symbol encodings and search controller state type
package mfa_pkg;
  localparam int SYM_W = 2;
  localparam logic [SYM_W-1:0] SYM_A = 2'b00;
  localparam logic [SYM_W-1:0] SYM_C = 2'b01;
  localparam logic [SYM_W-1:0] SYM_G = 2'b10;
  localparam logic [SYM_W-1:0] SYM_T = 2'b11;
  typedef enum logic [2:0] {IDLE, RUN, FETCH, UPDATE, FLUSH, DONE} state_t;
endpackage

// File: rtl/sym_fifo.sv
// sym_fifo: power-of-two symbol buffer with push/pop/clear and full/empty flags
module sym_fifo import mfa_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [SYM_W-1:0] din,
  output logic [SYM_W-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             single
);
  localparam int AW = $clog2(DEPTH);
  logic [SYM_W-1:0] mem_q [DEPTH];
  logic [SYM_W-1:0] mem_d [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (clear) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + 1'b1;
      end
      if (pop && !empty) rd_d = rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end
  assign empty  = wr_q == rd_q;
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign single = (wr_q - rd_q) == (AW+1)'(1);
  assign head   = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/search_ctrl.sv
// search_ctrl: buffers input symbols and steps a search datapath one symbol per fetch/update pair
module search_ctrl import mfa_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_LEN    = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               BC_mode,
  input  logic [SYM_W-1:0]   sym_in,
  input  logic               sym_valid,
  output logic               sym_ready,
  output logic [SYM_W-1:0]   dp_symbol,
  output logic               dp_fetch,
  output logic               dp_update,
  input  logic               dp_empty,
  output logic [CNT_LEN-1:0] sym_count,
  output logic               done,
  output logic               matched
);
  state_t state_q, state_d;
  logic [CNT_LEN-1:0] cnt_q, cnt_d;
  logic matched_q, matched_d;
  logic [SYM_W-1:0] f_head;
  logic f_full, f_empty, f_single, push;
  assign sym_ready = BC_mode && !f_full && (state_q == RUN || state_q == FETCH || state_q == UPDATE);
  assign push      = sym_valid && sym_ready;
  sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (CLK),
    .rst    (RST),
    .clear  (state_q == FLUSH),
    .push   (push),
    .pop    (state_q == UPDATE),
    .din    (sym_in),
    .head   (f_head),
    .full   (f_full),
    .empty  (f_empty),
    .single (f_single)
  );
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    matched_d = matched_q;
    case (state_q)
      IDLE, DONE: if (BC_mode) begin
        state_d   = RUN;
        cnt_d     = '0;
        matched_d = 1'b0;
      end
      RUN: if (!f_empty) state_d = FETCH;
        else if (!BC_mode) begin
          state_d   = DONE;
          matched_d = 1'b1;
        end
      FETCH: state_d = UPDATE;
      UPDATE: begin
        cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        // a same-cycle push keeps the buffer non-empty even when popping the last entry
        state_d = dp_empty ? FLUSH : (!f_single || push) ? FETCH : RUN;
      end
      FLUSH: begin
        state_d   = DONE;
        matched_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      matched_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      matched_q <= matched_d;
    end
  end
  assign dp_fetch  = state_q == FETCH;
  assign dp_update = state_q == UPDATE;
  assign dp_symbol = (dp_fetch || dp_update) ? f_head : SYM_A;
  assign sym_count = cnt_q;
  assign done      = state_q == DONE;
  assign matched   = matched_q;
endmodule

// File: tb/tb_search_ctrl.sv
// tb_search_ctrl: randomized sessions checked against a queue-based model of the search controller
module tb_search_ctrl;
  logic CLK = 1'b0, RST = 1'b1, BC_mode = 1'b0, sym_valid = 1'b0, dp_empty = 1'b0;
  logic [1:0] sym_in = 2'b00;
  logic sym_ready, dp_fetch, dp_update, done, matched;
  logic [1:0] dp_symbol;
  logic [15:0] sym_count;
  logic r2, f2, u2, d2, m2;
  logic [1:0] s2, c2;
  int n_tests = 0, n_fail = 0;
  logic [1:0] stim[$];
  logic [1:0] fetched[$];
  int upd_mon = 0, acc_n = 0, kill = 0;
  logic prev_fetch = 1'b0;

  search_ctrl dut (
    .CLK(CLK), .RST(RST), .BC_mode(BC_mode), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .dp_symbol(dp_symbol), .dp_fetch(dp_fetch), .dp_update(dp_update),
    .dp_empty(dp_empty), .sym_count(sym_count), .done(done), .matched(matched)
  );
  search_ctrl #(.FIFO_DEPTH(4), .CNT_LEN(2)) dut2 (
    .CLK(CLK), .RST(RST), .BC_mode(BC_mode), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(r2), .dp_symbol(s2), .dp_fetch(f2), .dp_update(u2),
    .dp_empty(dp_empty), .sym_count(c2), .done(d2), .matched(m2)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // protocol monitor: every update follows a fetch, idle symbol is A
  always @(negedge CLK) begin
    if (RST) prev_fetch = 1'b0;
    else begin
      n_tests++;
      if (dp_update !== prev_fetch) begin
        n_fail++;
        $display("FAIL upd_after_fetch: dp_update=%b prev_fetch=%b", dp_update, prev_fetch);
      end
      n_tests++;
      if (!(dp_fetch || dp_update) && dp_symbol !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_symbol: got %b want 00", dp_symbol);
      end
      if (dp_fetch) fetched.push_back(dp_symbol);
      if (dp_update) upd_mon++;
      prev_fetch = dp_fetch;
    end
  end

  // reports an empty interval on the kill-th update of the session
  always @(posedge CLK) begin
    #1;
    dp_empty = dp_update && kill != 0 && (upd_mon + 1 == kill);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (done) BC_mode = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    n_tests++;
    if ({sym_ready, dp_symbol, dp_fetch, dp_update, sym_count, done, matched} !== '0) begin
      n_fail++;
      $display("FAIL %s_outputs: got rdy=%b sym=%b f=%b u=%b cnt=%0d done=%b m=%b want all 0",
               tag, sym_ready, dp_symbol, dp_fetch, dp_update, sym_count, done, matched);
    end
    n_tests++;
    if ({r2, s2, f2, u2, c2, d2, m2} !== '0) begin
      n_fail++;
      $display("FAIL %s_outputs2: got cnt=%0d done=%b want all 0", tag, c2, d2);
    end
  endtask

  task automatic start_session(input string tag);
    BC_mode = 1'b1;
    fetched.delete();
    upd_mon = 0;
    acc_n = 0;
    tick();
    n_tests++;
    if (sym_count !== 16'd0 || c2 !== 2'd0) begin
      n_fail++;
      $display("FAIL %s_start_count: got %0d/%0d want 0", tag, sym_count, c2);
    end
    n_tests++;
    if (done !== 1'b0 || matched !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start_flags: got done=%b matched=%b want 0 0", tag, done, matched);
    end
  endtask

  task automatic session(input int kill_at, input int gmin, input int gmax, input string tag);
    int idx = 0, cyc = 0, k, n;
    logic acc, exp_m;
    kill = kill_at;
    n = stim.size();
    start_session(tag);
    while (idx < n && !done && cyc < 1000) begin
      repeat ($urandom_range(gmin, gmax)) begin
        sym_valid = 1'b0;
        tick();
        cyc++;
      end
      if (done) break;
      sym_valid = 1'b1;
      sym_in = stim[idx];
      #1;
      if (kill == 0) begin
        n_tests++;
        if (sym_ready !== ((acc_n - upd_mon) < 4)) begin
          n_fail++;
          $display("FAIL %s_ready: got %b with occupancy %0d", tag, sym_ready, acc_n - upd_mon);
        end
      end
      acc = sym_ready;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        acc_n++;
      end
    end
    sym_valid = 1'b0;
    BC_mode = 1'b0;
    n_tests++;
    if (idx < n && !done) begin
      n_fail++;
      $display("FAIL %s_push_timeout: pushed %0d want %0d", tag, idx, n);
    end
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    k = (kill_at == 0 || kill_at > n) ? n : kill_at;
    exp_m = (kill_at == 0 || kill_at > n);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: got %b want 1", tag, done);
    end
    n_tests++;
    if (matched !== exp_m) begin
      n_fail++;
      $display("FAIL %s_matched: got %b want %b", tag, matched, exp_m);
    end
    n_tests++;
    if (sym_count !== 16'(k)) begin
      n_fail++;
      $display("FAIL %s_count: got %0d want %0d", tag, sym_count, k);
    end
    n_tests++;
    if (c2 !== 2'((k > 3) ? 3 : k)) begin
      n_fail++;
      $display("FAIL %s_count_sat: got %0d want %0d", tag, c2, (k > 3) ? 3 : k);
    end
    n_tests++;
    if (upd_mon != k || fetched.size() != k) begin
      n_fail++;
      $display("FAIL %s_steps: got updates=%0d fetches=%0d want %0d", tag, upd_mon, fetched.size(), k);
    end
    for (int i = 0; i < k && i < fetched.size(); i++) begin
      n_tests++;
      if (fetched[i] !== stim[i]) begin
        n_fail++;
        $display("FAIL %s_order[%0d]: got %b want %b", tag, i, fetched[i], stim[i]);
      end
    end
    tick();
    tick();
    n_tests++;
    if (done !== 1'b1 || sym_count !== 16'(k) || matched !== exp_m || sym_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_hold: got done=%b cnt=%0d m=%b rdy=%b want 1 %0d %b 0",
               tag, done, sym_count, matched, sym_ready, k, exp_m);
    end
  endtask

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(2'($urandom_range(0, 3)));
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset");
    RST = 1'b0;
    tick();
    check_zero("idle");
  endtask

  task automatic test_basic();
    stim = {2'b01, 2'b10, 2'b11};
    session(0, 1, 1, "basic");
  endtask

  task automatic test_back_to_back();
    fill_random(8);
    session(0, 0, 0, "b2b");
  endtask

  task automatic test_flush();
    stim = {2'b11, 2'b00, 2'b10};
    session(2, 0, 0, "flush");
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    stim = {2'b01, 2'b10, 2'b11};
    kill = 0;
    start_session("rstmid");
    for (int i = 0; i < 3; i++) begin
      sym_valid = 1'b1;
      sym_in = stim[i];
      tick();
    end
    sym_valid = 1'b0;
    while (!(dp_fetch && upd_mon == 1) && cyc < 50) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (!(dp_fetch && upd_mon == 1)) begin
      n_fail++;
      $display("FAIL rstmid_second_fetch: got fetch=%b updates=%0d want 1 1", dp_fetch, upd_mon);
    end
    RST = 1'b1;
    BC_mode = 1'b0;
    #1;
    check_zero("rstmid");
    tick();
    tick();
    RST = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (upd_mon != 1) begin
      n_fail++;
      $display("FAIL rstmid_no_update: got updates=%0d want 1", upd_mon);
    end
    check_zero("rstmid_idle");
    fill_random(4);
    session(0, 0, 2, "after_rst");
  endtask

  task automatic test_saturate();
    fill_random(5);
    session(0, 0, 1, "sat");
    fill_random(1);
    session(0, 0, 0, "sat_restart");
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      int n = $urandom_range(1, 10);
      fill_random(n);
      session(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, n + 2), 0, 3, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
